// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, control bit positions and zero register for the pipeline
package pipeline_pkg;

    localparam int DATA_W       = 64;
    localparam int REG_AW       = 5;
    localparam int CTRL_W       = 12;
    localparam int ZERO_REG     = 31;
    localparam int CNT_W        = 32;

    // Bit positions inside the decoded control bundle
    localparam int CTRL_REGWR   = 0;
    localparam int CTRL_MEMREAD = 1;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - operand select between zero register, EX forward, MEM forward and register file
module fwd_mux #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int REG_AW   = pipeline_pkg::REG_AW,
    parameter int ZERO_REG = pipeline_pkg::ZERO_REG
) (
    input  logic [REG_AW-1:0] srcIdx,
    input  logic [DATA_W-1:0] busData,
    input  logic              exFwdEn,
    input  logic [REG_AW-1:0] exDst,
    input  logic [DATA_W-1:0] exResult,
    input  logic              memFwdEn,
    input  logic [REG_AW-1:0] memDst,
    input  logic [DATA_W-1:0] memResult,
    output logic [DATA_W-1:0] operand
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    // XZR always reads zero; the younger EX result wins over MEM
    always_comb begin
        operand = busData;
        if (srcIdx == ZERO_IDX) begin
            operand = '0;
        end else if (exFwdEn && (exDst == srcIdx)) begin
            operand = exResult;
        end else if (memFwdEn && (memDst == srcIdx)) begin
            operand = memResult;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use hazard and bubble counter
module id_ex_stage #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int REG_AW   = pipeline_pkg::REG_AW,
    parameter int CTRL_W   = pipeline_pkg::CTRL_W,
    parameter int ZERO_REG = pipeline_pkg::ZERO_REG,
    parameter int CNT_W    = pipeline_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    input  logic [REG_AW-1:0] RA_D,
    input  logic [REG_AW-1:0] RB_D,
    input  logic [REG_AW-1:0] RW_D,
    input  logic [DATA_W-1:0] Imm_D,
    input  logic [CTRL_W-1:0] Ctrl_D,
    input  logic              Valid_D,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ExResult,
    input  logic              MemRegWr,
    input  logic [REG_AW-1:0] MemRW,
    input  logic [DATA_W-1:0] MemResult,
    output logic [DATA_W-1:0] OpA_E,
    output logic [DATA_W-1:0] OpB_E,
    output logic [DATA_W-1:0] Imm_E,
    output logic [REG_AW-1:0] RA_E,
    output logic [REG_AW-1:0] RB_E,
    output logic [REG_AW-1:0] RW_E,
    output logic [CTRL_W-1:0] Ctrl_E,
    output logic              Valid_E,
    output logic              StallD,
    output logic [CNT_W-1:0]  BubbleCnt
);

    import pipeline_pkg::*;

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    logic              loadUse;
    logic              exFwdEn;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;

    // A load in E cannot forward yet: its data only exists once it reaches MEM
    always_comb begin
        exFwdEn = Valid_E && Ctrl_E[CTRL_REGWR] && !Ctrl_E[CTRL_MEMREAD];
        loadUse = Valid_E && Ctrl_E[CTRL_MEMREAD] && Ctrl_E[CTRL_REGWR] &&
                  (RW_E != ZERO_IDX) && Valid_D &&
                  ((RW_E == RA_D) || (RW_E == RB_D));
        StallD  = Stall || loadUse;
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .srcIdx   (RA_D),
        .busData  (BusA),
        .exFwdEn  (exFwdEn),
        .exDst    (RW_E),
        .exResult (ExResult),
        .memFwdEn (MemRegWr),
        .memDst   (MemRW),
        .memResult(MemResult),
        .operand  (opA)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .srcIdx   (RB_D),
        .busData  (BusB),
        .exFwdEn  (exFwdEn),
        .exDst    (RW_E),
        .exResult (ExResult),
        .memFwdEn (MemRegWr),
        .memDst   (MemRW),
        .memResult(MemResult),
        .operand  (opB)
    );

    // Pipeline register: flush beats stall, stall holds, hazard or empty slot loads a bubble
    always_ff @(posedge Clk) begin
        if (Reset || Flush || (!Stall && (loadUse || !Valid_D))) begin
            OpA_E   <= '0;
            OpB_E   <= '0;
            Imm_E   <= '0;
            RA_E    <= '0;
            RB_E    <= '0;
            RW_E    <= '0;
            Ctrl_E  <= '0;
            Valid_E <= 1'b0;
        end else if (!Stall) begin
            OpA_E   <= opA;
            OpB_E   <= opB;
            Imm_E   <= Imm_D;
            RA_E    <= RA_D;
            RB_E    <= RB_D;
            RW_E    <= RW_D;
            Ctrl_E  <= Ctrl_D;
            Valid_E <= 1'b1;
        end
    end

    // Count only bubbles actually caused by load-use; saturate instead of wrapping
    always_ff @(posedge Clk) begin
        if (Reset) begin
            BubbleCnt <= '0;
        end else if (!Flush && !Stall && loadUse && (BubbleCnt != '1)) begin
            BubbleCnt <= BubbleCnt + CNT_W'(1);
        end
    end

endmodule
